// File: rtl/riscv_pkg.sv
// Shared definitions for the multi-cycle RISC-V control path:
// state codes, opcodes, ALUOp/ALUControl encodings, immediate-type helper.
package riscv_pkg;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;

  typedef enum logic [3:0] {
    FETCH    = S_FETCH,
    DECODE   = S_DECODE,
    MEMADR   = S_MEMADR,
    MEMREAD  = S_MEMREAD,
    MEMWB    = S_MEMWB,
    MEMWRITE = S_MEMWRITE,
    EXECUTER = S_EXECUTER,
    EXECUTEI = S_EXECUTEI,
    ALUWB    = S_ALUWB,
    BEQ      = S_BEQ,
    JAL      = S_JAL
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_FN  = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;

  function automatic logic [1:0] imm_src(input logic [6:0] op);
    logic [1:0] r;
    r = 2'b00;
    unique case (1'b1)
      op == OP_SW:  r = 2'b01;
      op == OP_BEQ: r = 2'b10;
      op == OP_JAL: r = 2'b11;
      default:      r = 2'b00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: (aluop, funct3, op5, funct7b5) -> 3-bit ALU operation.
// Ports: aluop, funct3, op5, funct7b5 in; alucontrol out. Combinational.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FN: begin
        case (funct3)
          3'b000: begin
            // only R-type carries a real funct7; I-type bit 30 is imm
            if (op5 & funct7b5) alucontrol = ALU_SUB;
            else                alucontrol = ALU_ADD;
          end
          3'b010:  alucontrol = ALU_SLT;
          3'b100:  alucontrol = ALU_XOR;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_multicycle_controller.sv
// Moore control FSM of the multi-cycle RV32I core; drives mux selects,
// write enables, ImmSrc, ALUControl, Illegal. Option: CONTROLLER_BNE_EN.
module riscv_multicycle_controller
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic [2:0] ALUControl,
  output logic       Illegal
);

  state_t     state, next;
  logic       pcupdate, branch, take;
  logic       memw, irw, regw;
  logic [1:0] aluop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= next;
  end

  always_comb begin
    next      = FETCH;
    pcupdate  = 1'b0;
    branch    = 1'b0;
    AdrSrc    = 1'b0;
    memw      = 1'b0;
    irw       = 1'b0;
    regw      = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    aluop     = ALUOP_ADD;
    Illegal   = 1'b0;
    case (state)
      FETCH: begin
        irw       = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        pcupdate  = 1'b1;
        next      = DECODE;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        unique case (1'b1)
          (op == OP_LW) || (op == OP_SW): next = MEMADR;
          op == OP_R:   next = EXECUTER;
          op == OP_I:   next = EXECUTEI;
          op == OP_JAL: next = JAL;
          op == OP_BEQ: begin
`ifdef CONTROLLER_BNE_EN
            if (funct3[2:1] == 2'b00) next = BEQ;
            else                      Illegal = 1'b1;
`else
            next = BEQ;
`endif
          end
          default: Illegal = 1'b1;
        endcase
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        next    = (op == OP_SW) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        next   = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        regw      = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        memw   = 1'b1;
      end
      EXECUTER: begin
        ALUSrcA = 2'b10;
        aluop   = ALUOP_FN;
        next    = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        aluop   = ALUOP_FN;
        next    = ALUWB;
      end
      ALUWB: regw = 1'b1;
      BEQ: begin
        ALUSrcA = 2'b10;
        aluop   = ALUOP_SUB;
        branch  = 1'b1;
      end
      JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        pcupdate = 1'b1;
        next     = ALUWB;
      end
      default: next = FETCH;
    endcase
  end

`ifdef CONTROLLER_BNE_EN
  // funct3[0] set means bne: branch on a nonzero difference
  assign take = Zero ^ funct3[0];
`else
  assign take = Zero;
`endif

  // write enables are held off for the whole reset window
  assign PCWrite  = ~reset & (pcupdate | (branch & take));
  assign IRWrite  = ~reset & irw;
  assign MemWrite = ~reset & memw;
  assign RegWrite = ~reset & regw;
  assign ImmSrc   = imm_src(op);

  alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct3     (funct3),
    .op5        (op[5]),
    .funct7b5   (funct7b5),
    .alucontrol (ALUControl)
  );

endmodule

// File: tb/tb_riscv_multicycle_controller.sv
// Scoreboard bench for riscv_multicycle_controller: per-instruction
// expected control vectors are queued, a negedge monitor compares them.
module tb_riscv_multicycle_controller;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic [1:0] res;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] imm;
    logic       regw;
    logic [2:0] alu;
    logic       ill;
  } vec_t;

  typedef enum {K_LOAD, K_STORE, K_RT, K_IT, K_BR, K_JMP, K_BAD} kind_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       Zero = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic       Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  vec_t  act;
  vec_t  expq[$];
  string tagq[$];
  vec_t  mexp;
  string mtag;
  int    pass_cnt = 0;
  int    total = 0;

  riscv_multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .RegWrite   (RegWrite),
    .ALUControl (ALUControl),
    .Illegal    (Illegal)
  );

  always #5 clk = ~clk;

  assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
                ALUSrcA, ALUSrcB, ImmSrc, RegWrite, ALUControl,
                Illegal};

  task automatic chk(input string nm, input vec_t a, input vec_t e);
    total++;
    if (a === e) pass_cnt++;
    else $display("FAIL %s: got %h want %h", nm, a, e);
  endtask

  always @(negedge clk) begin
    if (!reset && expq.size() != 0) begin
      mexp = expq.pop_front();
      mtag = tagq.pop_front();
      chk(mtag, act, mexp);
    end
  end

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  function automatic kind_t kind_of(input logic [6:0] o,
                                    input logic [2:0] f3);
    case (o)
      7'b0000011: return K_LOAD;
      7'b0100011: return K_STORE;
      7'b0110011: return K_RT;
      7'b0010011: return K_IT;
      7'b1101111: return K_JMP;
      7'b1100011: begin
`ifdef CONTROLLER_BNE_EN
        if (f3 == 3'b000 || f3 == 3'b001) return K_BR;
        return K_BAD;
`else
        if (f3 == 3'b111 || f3 != 3'b111) return K_BR;
        return K_BAD;
`endif
      end
      default: return K_BAD;
    endcase
  endfunction

  function automatic logic [2:0] alu_fn(input logic [2:0] f3,
                                        input logic sub);
    case (f3)
      3'b000:  return sub ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b100:  return 3'b011;
      3'b110:  return 3'b110;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic vec_t blank(input logic [1:0] im);
    vec_t v;
    v = '0;
    v.imm = im;
    return v;
  endfunction

  task automatic push(input string t, input vec_t v);
    expq.push_back(v);
    tagq.push_back(t);
  endtask

  // Build the full cycle-by-cycle expectation of one instruction.
  task automatic issue(input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, input logic z, output int n);
    vec_t  v;
    kind_t k;
    logic [1:0] im;
    logic tk;
    im = imm_of(o);
    k  = kind_of(o, f3);
    v = blank(im);
    v.pcw = 1; v.irw = 1; v.sb = 2'b10; v.res = 2'b10;
    push("fetch", v);
    v = blank(im);
    v.sa = 2'b01; v.sb = 2'b01; v.ill = (k == K_BAD);
    push("decode", v);
    n = 2;
    case (k)
      K_LOAD, K_STORE: begin
        v = blank(im); v.sa = 2'b10; v.sb = 2'b01;
        push("memadr", v);
        v = blank(im); v.adr = 1;
        if (k == K_STORE) begin
          v.memw = 1;
          push("memwrite", v);
          n = 4;
        end else begin
          push("memread", v);
          v = blank(im); v.res = 2'b01; v.regw = 1;
          push("memwb", v);
          n = 5;
        end
      end
      K_RT, K_IT: begin
        v = blank(im); v.sa = 2'b10;
        v.sb = (k == K_IT) ? 2'b01 : 2'b00;
        v.alu = alu_fn(f3, (k == K_RT) && f7);
        push(k == K_RT ? "execr" : "execi", v);
        v = blank(im); v.regw = 1;
        push("aluwb", v);
        n = 4;
      end
      K_JMP: begin
        v = blank(im); v.sa = 2'b01; v.sb = 2'b10; v.pcw = 1;
        push("jal", v);
        v = blank(im); v.regw = 1;
        push("aluwb", v);
        n = 4;
      end
      K_BR: begin
`ifdef CONTROLLER_BNE_EN
        tk = z ^ f3[0];
`else
        tk = z;
`endif
        v = blank(im); v.sa = 2'b10; v.alu = 3'b001; v.pcw = tk;
        push("beq", v);
        n = 3;
      end
      default: n = 2;
    endcase
  endtask

  task automatic run(input logic [6:0] o, input logic [2:0] f3,
                     input logic f7, input logic z);
    int n;
    op = o; funct3 = f3; funct7b5 = f7; Zero = z;
    issue(o, f3, f7, z, n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [6:0] dop[14] = '{7'b0000011, 7'b0110011, 7'b0110011,
                          7'b0010011, 7'b1100011, 7'b1100011,
                          7'b0010011, 7'b0010011, 7'b0010011,
                          7'b0010011, 7'b0010011, 7'b0110111,
                          7'b0100011, 7'b1101111};
  logic [2:0] df3[14] = '{3'b010, 3'b000, 3'b000, 3'b000, 3'b000,
                          3'b000, 3'b010, 3'b100, 3'b110, 3'b111,
                          3'b001, 3'b000, 3'b010, 3'b000};
  logic       df7[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                          1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic       dz[14]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                          1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [6:0] legal[6] = '{7'b0000011, 7'b0100011, 7'b0110011,
                           7'b0010011, 7'b1100011, 7'b1101111};

  initial begin
    vec_t rv;
    int   k;
    logic [6:0] o;
    rv = blank(2'b00);
    rv.sb = 2'b10; rv.res = 2'b10;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", act, rv);
    @(posedge clk);
    #1 reset = 1'b0;

    // lw interrupted by reset while in MEMREAD
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 0; Zero = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1 chk("rst_async", act, rv);
    @(negedge clk);
    chk("rst_hold", act, rv);
    @(posedge clk);
    #1 chk("rst_edge", act, rv);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) run(dop[i], df3[i], df7[i], dz[i]);
`ifdef CONTROLLER_BNE_EN
    run(7'b1100011, 3'b001, 1'b0, 1'b0);
    run(7'b1100011, 3'b001, 1'b0, 1'b1);
    run(7'b1100011, 3'b100, 1'b0, 1'b0);
`else
    run(7'b1100011, 3'b001, 1'b0, 1'b1);
    run(7'b1100011, 3'b101, 1'b0, 1'b0);
`endif

    for (int i = 0; i < 200; i++) begin
      k = $urandom_range(0, 7);
      if (k < 6) o = legal[k];
      else       o = 7'($urandom_range(0, 127));
      run(o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)));
    end

    k = 0;
    while (expq.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (expq.size() != 0) begin
      total++;
      $display("FAIL drain: %0d entries left want 0", expq.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
